// File: rtl/seg7_pkg.sv
// Shared types and constants for the memory-mapped seven-segment display controller.
// Holds digit register layout, bus FSM states, decode table and the CTRL index helper.
package seg7_pkg;

    localparam int DIG_HEX_LSB   = 0;
    localparam int DIG_DP_BIT    = 4;
    localparam int DIG_BLANK_BIT = 5;
    localparam int DIG_BLINK_BIT = 6;
    localparam int DIG_RAW_BIT   = 7;
    localparam int DIG_SEG_LSB   = 8;
    localparam int DIGIT_BITS    = 16;
    localparam int CTRL_BITS     = 24;

    typedef struct packed {
        logic [7:0] raw_seg;
        logic       raw;
        logic       blink;
        logic       blank;
        logic       dp;
        logic [3:0] hex;
    } digit_reg_t;

    localparam digit_reg_t DIGIT_RESET = digit_reg_t'(16'h0020);

    typedef enum logic {
        BUS_IDLE,
        BUS_ACK
    } bus_state_e;

    // Active-high gfedcba patterns, entry 0 is the rightmost element.
    localparam logic [15:0][6:0] DECODE_LUT = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic int ctrl_index(input int aw);
        return (1 << aw) - 1;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to active-high gfedcba segment pattern.
// Zero latency, no flow control.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    assign seg_o = DECODE_LUT[hex_i];

endmodule

// File: rtl/seg7_display_ctrl.sv
// Wishbone B3 slave driving NUM_DIGITS seven-segment digits with per-digit blink/raw/blank.
// One wait state per access (ack at T+1, never back-to-back); seg7 lags register writes by one cycle.
module seg7_display_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int ADDR_WIDTH = 4,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    wb_cyc,
    input  logic                    wb_stb,
    input  logic                    wb_we,
    input  logic [ADDR_WIDTH-1:0]   wb_adr,
    input  logic [31:0]             wb_dat_w,
    input  logic [3:0]              wb_sel,
    output logic [31:0]             wb_dat_r,
    output logic                    wb_ack,
    output logic [NUM_DIGITS*8-1:0] seg7
);

    localparam logic [ADDR_WIDTH-1:0] CTRL_IDX = ADDR_WIDTH'(ctrl_index(ADDR_WIDTH));

    bus_state_e             state_q, state_d;
    digit_reg_t             digit_q [NUM_DIGITS];
    digit_reg_t             digit_d [NUM_DIGITS];
    logic [CTRL_BITS-1:0]   div_q, div_d;
    logic [CTRL_BITS-1:0]   cnt_q, cnt_d;
    logic                   phase_q, phase_d;
    logic [31:0]            dat_r_q, dat_r_d;
    logic [NUM_DIGITS*8-1:0] seg_q, seg_d;
    logic                   req;
    logic                   ctrl_wr;
    logic [6:0]             dec_seg [NUM_DIGITS];

    // Top byte lane never maps to a register field.
    logic unused_ok;
    assign unused_ok = ^{wb_sel[3], wb_dat_w[31:24]};

    function automatic logic [7:0] digit_pattern(input digit_reg_t d,
                                                 input logic [6:0] dec,
                                                 input logic       phase);
        logic [7:0] p;
        if (d[DIG_BLANK_BIT] || (d[DIG_BLINK_BIT] && !phase)) begin
            p = 8'h00;
        end else if (d[DIG_RAW_BIT]) begin
            p = d[DIG_SEG_LSB +: 8];
        end else begin
            p = {d[DIG_DP_BIT], dec};
        end
        return p;
    endfunction

    assign req = wb_cyc && wb_stb && (state_q == BUS_IDLE);

    always_comb begin
        state_d = BUS_IDLE;
        dat_r_d = '0;
        digit_d = digit_q;
        div_d   = div_q;
        ctrl_wr = 1'b0;
        if (req) begin
            state_d = BUS_ACK;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (wb_adr == ADDR_WIDTH'(i)) begin
                    dat_r_d = {{(32-DIGIT_BITS){1'b0}}, digit_q[i]};
                    if (wb_we) begin
                        for (int b = 0; b < DIGIT_BITS/8; b++) begin
                            if (wb_sel[b]) digit_d[i][8*b +: 8] = wb_dat_w[8*b +: 8];
                        end
                    end
                end
            end
            if (wb_adr == CTRL_IDX) begin
                dat_r_d = {{(32-CTRL_BITS){1'b0}}, div_q};
                if (wb_we) begin
                    ctrl_wr = 1'b1;
                    for (int b = 0; b < CTRL_BITS/8; b++) begin
                        if (wb_sel[b]) div_d[8*b +: 8] = wb_dat_w[8*b +: 8];
                    end
                end
            end
        end
    end

    // A CTRL write restarts the blink period even if the counter expires on the same edge.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (ctrl_wr) begin
            cnt_d   = div_d;
            phase_d = 1'b1;
        end else if (div_q == '0) begin
            cnt_d   = '0;
            phase_d = 1'b1;
        end else if (cnt_q == '0) begin
            cnt_d   = div_q;
            phase_d = ~phase_q;
        end else begin
            cnt_d   = cnt_q - 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        seg7_decode u_decode (
            .hex_i (digit_q[g][DIG_HEX_LSB +: 4]),
            .seg_o (dec_seg[g])
        );
    end

    always_comb begin
        seg_d = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            seg_d[8*i +: 8] = ACTIVE_LOW ? ~digit_pattern(digit_q[i], dec_seg[i], phase_q)
                                         :  digit_pattern(digit_q[i], dec_seg[i], phase_q);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= BUS_IDLE;
            dat_r_q <= '0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digit_q[i] <= DIGIT_RESET;
            end
            div_q   <= '0;
            cnt_q   <= '0;
            phase_q <= 1'b1;
            seg_q   <= {(NUM_DIGITS*8){ACTIVE_LOW}};
        end else begin
            state_q <= state_d;
            dat_r_q <= dat_r_d;
            digit_q <= digit_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            seg_q   <= seg_d;
        end
    end

    assign wb_ack   = (state_q == BUS_ACK);
    assign wb_dat_r = dat_r_q;
    assign seg7     = seg_q;

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// Directed bench for seg7_display_ctrl: vector table for register accesses plus
// hand-timed sequences for blink, mid-transaction reset and back-to-back writes.
module tb_seg7_display_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        wb_cyc, wb_stb, wb_we;
    logic [3:0]  wb_adr;
    logic [31:0] wb_dat_w;
    logic [3:0]  wb_sel;
    logic [31:0] wb_dat_r;
    logic        wb_ack;
    logic [31:0] seg7;

    int n_pass  = 0;
    int n_total = 0;

    seg7_display_ctrl #(
        .NUM_DIGITS (4),
        .ADDR_WIDTH (4),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .wb_cyc   (wb_cyc),
        .wb_stb   (wb_stb),
        .wb_we    (wb_we),
        .wb_adr   (wb_adr),
        .wb_dat_w (wb_dat_w),
        .wb_sel   (wb_sel),
        .wb_dat_r (wb_dat_r),
        .wb_ack   (wb_ack),
        .seg7     (seg7)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        we;
        logic [3:0]  adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [31:0] exp_rd;
        logic [31:0] exp_seg;
    } vec_t;

    vec_t vt [19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Entered and left at a negedge; the request is sampled on the next posedge.
    task automatic bus_op(input logic we, input logic [3:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, output logic [31:0] rd);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we;
        wb_adr = adr; wb_dat_w = dat; wb_sel = sel;
        @(posedge clock); @(negedge clock);
        check("ack_pulse", {31'b0, wb_ack}, 32'd1);
        rd = wb_dat_r;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        @(posedge clock); @(negedge clock);
        check("ack_drop", {31'b0, wb_ack}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int          idx;

        vt[0]  = '{1'b0, 4'h0, 32'h0,        4'h0, 32'h00000020, 32'hFFFFFFFF};
        vt[1]  = '{1'b1, 4'h0, 32'h0000000A, 4'h1, 32'h0,        32'hFFFFFF88};
        vt[2]  = '{1'b0, 4'h0, 32'h0,        4'h0, 32'h0000000A, 32'hFFFFFF88};
        vt[3]  = '{1'b1, 4'h1, 32'h0000B380, 4'h3, 32'h0,        32'hFFFF4C88};
        vt[4]  = '{1'b1, 4'h1, 32'h00000000, 4'h2, 32'h0,        32'hFFFFFF88};
        vt[5]  = '{1'b0, 4'h1, 32'h0,        4'h0, 32'h00000080, 32'hFFFFFF88};
        vt[6]  = '{1'b1, 4'h3, 32'h00000015, 4'h1, 32'h0,        32'h12FFFF88};
        vt[7]  = '{1'b1, 4'h3, 32'hFFFFFF00, 4'h0, 32'h0,        32'h12FFFF88};
        vt[8]  = '{1'b0, 4'h3, 32'h0,        4'h0, 32'h00000015, 32'h12FFFF88};
        vt[9]  = '{1'b1, 4'h5, 32'hFFFFFFFF, 4'hF, 32'h0,        32'h12FFFF88};
        vt[10] = '{1'b0, 4'h5, 32'h0,        4'h0, 32'h00000000, 32'h12FFFF88};
        vt[11] = '{1'b1, 4'hF, 32'hAB000000, 4'h8, 32'h0,        32'h12FFFF88};
        vt[12] = '{1'b0, 4'hF, 32'h0,        4'h0, 32'h00000000, 32'h12FFFF88};
        vt[13] = '{1'b1, 4'h3, 32'h00000020, 4'h1, 32'h0,        32'hFFFFFF88};
        vt[14] = '{1'b1, 4'h2, 32'h00000008, 4'h1, 32'h0,        32'hFF80FF88};
        vt[15] = '{1'b1, 4'hF, 32'h00123456, 4'h5, 32'h0,        32'hFF80FF88};
        vt[16] = '{1'b0, 4'hF, 32'h0,        4'h0, 32'h00120056, 32'hFF80FF88};
        vt[17] = '{1'b1, 4'hF, 32'h00000000, 4'hF, 32'h0,        32'hFF80FF88};
        vt[18] = '{1'b0, 4'h0, 32'h0,        4'h0, 32'h0000000A, 32'hFF80FF88};

        reset = 1'b1;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        wb_adr = '0; wb_dat_w = '0; wb_sel = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_seg7", seg7, 32'hFFFFFFFF);
        check("rst_ack", {31'b0, wb_ack}, 32'd0);
        check("rst_dat_r", wb_dat_r, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 19; i++) begin
            bus_op(vt[i].we, vt[i].adr, vt[i].dat, vt[i].sel, rd);
            if (!vt[i].we) check($sformatf("vec%0d_rd", i), rd, vt[i].exp_rd);
            check($sformatf("vec%0d_seg", i), seg7, vt[i].exp_seg);
        end

        // Blink: CTRL request at edge E0, DIGIT[2] request at E2, now just after E3.
        bus_op(1'b1, 4'hF, 32'h00000003, 4'hF, rd);
        bus_op(1'b1, 4'h2, 32'h00000041, 4'h1, rd);
        for (int k = 3; k <= 22; k++) begin
            if (k > 3) begin
                @(posedge clock); @(negedge clock);
            end
            check($sformatf("blink_k%0d", k), {24'b0, seg7[23:16]},
                  ((((k - 1) / 4) % 2) == 0) ? 32'h000000F9 : 32'h000000FF);
        end

        // Reset lands on the same edge as a write request.
        reset = 1'b1;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1;
        wb_adr = 4'h0; wb_dat_w = 32'h00000003; wb_sel = 4'hF;
        @(posedge clock); @(negedge clock);
        check("midrst_ack", {31'b0, wb_ack}, 32'd0);
        check("midrst_seg7", seg7, 32'hFFFFFFFF);
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        bus_op(1'b0, 4'h0, 32'h0, 4'h0, rd);
        check("postrst_digit0", rd, 32'h00000020);
        bus_op(1'b0, 4'hF, 32'h0, 4'h0, rd);
        check("postrst_ctrl", rd, 32'h00000000);
        bus_op(1'b1, 4'h2, 32'h00000041, 4'h1, rd);
        for (int k = 0; k < 10; k++) begin
            check("postrst_phase", {24'b0, seg7[23:16]}, 32'h000000F9);
            @(posedge clock); @(negedge clock);
        end

        // Back-to-back writes with cyc/stb held high.
        idx = 0;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1;
        wb_sel = 4'h1; wb_adr = 4'h0; wb_dat_w = 32'h0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clock); @(negedge clock);
            check($sformatf("b2b_ack_c%0d", c), {31'b0, wb_ack}, (c % 2 == 0) ? 32'd1 : 32'd0);
            if (wb_ack) begin
                idx++;
                if (idx < 4) begin
                    wb_adr = 4'(idx);
                    wb_dat_w = 32'(idx);
                end else begin
                    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
                end
            end
        end
        check("b2b_ack_count", 32'(idx), 32'd4);
        check("b2b_seg7", seg7, 32'hB0A4F9C0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/seg7_display_ctrl.md
# seg7_display_ctrl

Wishbone B3 slave peripheral that drives a parametrised number of seven-segment digits from a memory-mapped register file. Each digit has its own hex value, decimal point, blank, blink and raw-segment mode, and a shared programmable blink prescaler. The block sits on the processor data bus and replaces hard-wired switch-to-display decoding at the top level.

## Interface

Parameters:
- NUM_DIGITS, 4, number of digits driven; 1..(2^ADDR_WIDTH − 1).
- ADDR_WIDTH, 4, word-address bits decoded (adr is a word index).
- ACTIVE_LOW, 1, 1 = segment outputs inverted (board LEDs lit on 0).

Ports:
- clock  in  1  sole clock; all state on its rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- wb_cyc  in  1  bus cycle valid.
- wb_stb  in  1  strobe.
- wb_we  in  1  1 = write.
- wb_adr  in  ADDR_WIDTH  word index.
- wb_dat_w  in  32  write data.
- wb_sel  in  4  byte-lane enables; sel[n] covers bits 8n+7:8n.
- wb_dat_r  out  32  read data, valid while wb_ack = 1.
- wb_ack  out  1  single-cycle acknowledge.
- seg7  out  NUM_DIGITS*8  digit i at bits 8i+7:8i; bit 0 = segment a … bit 6 = g, bit 7 = dp.

## Operation

- Register map:
  - DIGIT[i] at index i for i < NUM_DIGITS.
  - CTRL at index 2^ADDR_WIDTH − 1.
  - Every other index is unmapped: acked, reads 0, writes ignored.
- DIGIT[i] fields (16 bits used; bits 31:16 read 0):
  - [3:0] hex value.
  - [4] dp.
  - [5] blank.
  - [6] blink.
  - [7] raw.
  - [15:8] raw segment pattern (active-high, dp in bit 15).
- CTRL fields: [23:0] BLINK_DIV; bits 31:24 read 0.
- Segment pattern per digit, before polarity inversion:
  - blank = 1, or (blink = 1 and phase = 0): 8'h00.
  - else raw = 1: bits [15:8].
  - else: {dp, decode(hex)}.
- Decode, active-high gfedcba: 0→3F, 1→06, 2→5B, 3→4F, 4→66, 5→6D, 6→7D, 7→07, 8→7F, 9→6F, A→77, b→7C, C→39, d→5E, E→79, F→71.
- Polarity: ACTIVE_LOW = 1 inverts all 8 bits.
- Blink prescaler:
  - 24-bit down-counter plus phase bit.
  - If BLINK_DIV = 0: phase is held at 1 and the counter at 0.
  - Otherwise, each cycle: counter = 0 → reload BLINK_DIV and toggle phase; else decrement.
  - Any accepted write to CTRL (any sel) loads counter = new BLINK_DIV and sets phase = 1.
- Byte writes: only lanes with sel = 1 are updated; lanes beyond the register width are ignored.

## Timing

- Request = wb_cyc & wb_stb & !wb_ack.
- Request at edge T: register write and wb_ack = 1 take effect at T+1. wb_dat_r is registered and valid in the same cycle as wb_ack.
- wb_ack is forced to 0 in the cycle after it was 1. This gives a one-wait-state classic cycle; back-to-back requests are acked every other cycle.
- A master dropping wb_stb before ack: no ack is generated and no side effect occurs, except a request already sampled at T still completes at T+1.
- seg7 is registered: a DIGIT write acked at T+1 appears on seg7 at T+2.
- A blink phase change appears on seg7 one cycle later.
- Reset values:
  - wb_ack = 0, wb_dat_r = 0.
  - DIGIT[i] = 16'h0020 (blank).
  - CTRL = 0, counter = 0, phase = 1.
  - seg7 = all 1s if ACTIVE_LOW, else all 0s.
- Reset mid-transaction: the pending ack is dropped and no write occurs.
- Simultaneous CTRL write and counter expiry: the write wins (reload, phase = 1).

## Structure

- Package seg7_pkg holds:
  - DIGIT field bit positions.
  - CTRL index function of ADDR_WIDTH.
  - Decode constant table.
  - A typedef struct for the digit register.
- One sub-module, seg7_decode: combinational 4-bit to 7-segment, active-high, instantiated NUM_DIGITS times.
- The prescaler, bus FSM (IDLE/ACK) and register file live in the top module.

## Test plan

- Reset hold 3 cycles, default params → seg7 = 32'hFFFFFFFF, wb_ack = 0; read index 0 → 32'h00000020.
- Write DIGIT[0] = 32'h0000000A with sel = 4'b0001 → ack exactly one cycle after strobe; seg7[7:0] = 8'h88 two cycles after strobe; other digits unchanged.
- Write DIGIT[1] = 32'h0000B380 with sel = 4'b0011 → seg7[15:8] = ~8'hB3 = 8'h4C. Then write 32'h00000000 with sel = 4'b0010 → raw bit kept, pattern 00, seg7[15:8] = 8'hFF.
- Write CTRL = 3, DIGIT[2] = 32'h41 (blink, hex 1) → seg7[23:16] alternates between 8'hF9 and 8'hFF every 4 cycles. Assert reset mid-period → seg7 returns to all 1s, and after reset phase = 1 with CTRL = 0.
- Read and write index 5 (unmapped, ADDR_WIDTH = 4) → acked; read returns 0; no register changes.
- Hold cyc/stb high across 4 back-to-back writes → ack pulses on alternate cycles, 4 acks total, all 4 digits updated in order.
